quad_7seg_scanner: RTL and testbench

QUAD_7SEG_SCANNER -- requirements
Module: quad_7seg_scanner

---
 rtl/quad_7seg_pkg.sv | 23 ++
 rtl/single_7seg.sv | 12 +
 rtl/quad_7seg_scanner.sv | 139 +++++++++++++
 tb/tb_quad_7seg_scanner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/quad_7seg_pkg.sv
// Shared definitions for the four-digit seven-segment scanner: scan states,
// digit count, blank pattern and the hex glyph table ({g,f,e,d,c,b,a}, active-high).
package quad_7seg_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [7:0]            SEG_BLANK = 8'hFF;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF   = '1;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_t;

   // Indexed by nibble value; the first entry in the concatenation is F.
   localparam logic [15:0][6:0] HEX_GLYPH = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
      7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

endpackage

// File: rtl/single_7seg.sv
// Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}; purely combinational,
// zero latency, no flow control.
module single_7seg
   import quad_7seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/quad_7seg_scanner.sv
// Time-multiplexed four-digit scanner with per-slot ghost blanking and frame-aligned
// double-buffered updates; new data shows from the next frame, load is never back-pressured.
module quad_7seg_scanner
   import quad_7seg_pkg::*;
#(
   parameter int CLK_HZ       = 27000000,
   parameter int DIGIT_HZ     = 1000,
   parameter int BLANK_CYCLES = 270,
   parameter int LZ_BLANK     = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic                      load,
   output logic                      load_ack,
   output logic                      frame_start,
   output logic [7:0]                seg_n,
   output logic [NUM_DIGITS-1:0]     digit_en_n
);

   localparam int DWELL = CLK_HZ / DIGIT_HZ;
   localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   if (DWELL <= BLANK_CYCLES) begin : g_bad_dwell
      $error("quad_7seg_scanner: DWELL must exceed BLANK_CYCLES");
   end
   if (BLANK_CYCLES < 1) begin : g_bad_blank
      $error("quad_7seg_scanner: BLANK_CYCLES must be at least 1");
   end

   scan_state_t                 state;
   logic [1:0]                  idx;
   logic [CNT_W-1:0]            cnt;

   logic [4*NUM_DIGITS-1:0]     stage_val;
   logic [NUM_DIGITS-1:0]       stage_dp;
   logic                        pending;
   logic [4*NUM_DIGITS-1:0]     disp_val;
   logic [NUM_DIGITS-1:0]       disp_dp;

   logic [3:0]                  nibble;
   logic [6:0]                  glyph;
   logic                        lz_hide;
   logic [7:0]                  show_seg;

   // Frame start is gated by rst so it stays low while reset is held but fires
   // on the very first cycle after release, when the counters sit at zero.
   assign frame_start = !rst && (idx == 2'd0) && (cnt == '0);
   assign load_ack    = frame_start && pending;

   assign nibble = disp_val[{idx, 2'b00} +: 4];

   single_7seg u_dec (
      .nibble (nibble),
      .seg    (glyph)
   );

   always_comb begin
      lz_hide = 1'b0;
      if (LZ_BLANK != 0) begin
         case (idx)
            2'd3:    lz_hide = (disp_val[15:12] == 4'h0);
            2'd2:    lz_hide = (disp_val[15:8]  == 8'h0);
            2'd1:    lz_hide = (disp_val[15:4]  == 12'h0);
            default: lz_hide = 1'b0;
         endcase
      end
   end

   assign show_seg = ~{disp_dp[idx], (lz_hide ? 7'h00 : glyph)};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_BLANK;
         idx        <= 2'd0;
         cnt        <= '0;
         seg_n      <= SEG_BLANK;
         digit_en_n <= DIG_OFF;
         stage_val  <= '0;
         stage_dp   <= '0;
         pending    <= 1'b0;
         disp_val   <= '0;
         disp_dp    <= '0;
      end else begin
         // A load on the transfer cycle lands in staging after the old contents
         // have been copied, so it stays pending for the following frame.
         if (load) begin
            stage_val <= value;
            stage_dp  <= dp;
         end
         if (load) begin
            pending <= 1'b1;
         end else if (load_ack) begin
            pending <= 1'b0;
         end
         if (load_ack) begin
            disp_val <= stage_val;
            disp_dp  <= stage_dp;
         end

         case (state)
            ST_BLANK: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_BLANK_LAST) begin
                  state      <= ST_SHOW;
                  seg_n      <= show_seg;
                  digit_en_n <= ~(NUM_DIGITS'(1) << idx);
               end else begin
                  seg_n      <= SEG_BLANK;
                  digit_en_n <= DIG_OFF;
               end
            end
            ST_SHOW: begin
               if (cnt == CNT_LAST) begin
                  state      <= ST_BLANK;
                  cnt        <= '0;
                  idx        <= idx + 1'b1;
                  seg_n      <= SEG_BLANK;
                  digit_en_n <= DIG_OFF;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state      <= ST_BLANK;
               cnt        <= '0;
               idx        <= 2'd0;
               seg_n      <= SEG_BLANK;
               digit_en_n <= DIG_OFF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_quad_7seg_scanner.sv
// Bench for quad_7seg_scanner at DWELL=10, BLANK_CYCLES=2: a cycle model checks every output
// each cycle while directed steps push expected display contents to a scoreboard popped on load_ack.
module tb_quad_7seg_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp;

   logic        load_ack, frame_start;
   logic [7:0]  seg_n;
   logic [3:0]  digit_en_n;
   logic        load_ack_lz, frame_start_lz;
   logic [7:0]  seg_n_lz;
   logic [3:0]  digit_en_n_lz;

   int checks   = 0;
   int failures = 0;
   int sc       = 0;

   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  d;
   } disp_t;

   disp_t exp_q[$];

   always #5 clk = ~clk;

   quad_7seg_scanner #(
      .CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYCLES(2), .LZ_BLANK(0)
   ) dut (
      .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
      .load_ack(load_ack), .frame_start(frame_start),
      .seg_n(seg_n), .digit_en_n(digit_en_n)
   );

   quad_7seg_scanner #(
      .CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYCLES(2), .LZ_BLANK(1)
   ) dut_lz (
      .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
      .load_ack(load_ack_lz), .frame_start(frame_start_lz),
      .seg_n(seg_n_lz), .digit_en_n(digit_en_n_lz)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] glyph_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] d,
                                          input int i, input bit lz);
      logic [6:0]  g;
      logic [15:0] higher;
      g      = glyph_of(v[i*4 +: 4]);
      higher = v >> (i*4);
      if (lz && i > 0 && higher == 16'h0) g = 7'h00;
      return ~{d[i], g};
   endfunction

   // Cycle model: c counts cycles since the last reset edge; cur is the expected display.
   int    c        = 0;
   logic  rst_prev = 1'b1;
   disp_t cur      = '0;

   always @(negedge clk) begin : monitor
      int         k, di;
      logic       efs;
      logic [3:0] ed;
      logic [7:0] es, esl;
      if (rst_prev) begin
         c   = 0;
         cur = '0;
      end else begin
         c = c + 1;
      end
      k   = c % 10;
      di  = (c / 10) % 4;
      efs = !rst && (c % 40 == 0);
      check("frame_start", 16'(frame_start), 16'(efs));
      check("frame_start_lz", 16'(frame_start_lz), 16'(efs));
      if (!efs) check("ack_outside_frame_start", 16'(load_ack), 16'h0);
      if (load_ack === 1'b1) begin
         check("ack_has_scoreboard_entry", 16'(exp_q.size() > 0), 16'h1);
         if (exp_q.size() > 0) cur = exp_q.pop_front();
      end
      if (k < 2) begin
         ed  = 4'hF;
         es  = 8'hFF;
         esl = 8'hFF;
      end else begin
         ed  = ~(4'b0001 << di);
         es  = exp_seg(cur.v, cur.d, di, 1'b0);
         esl = exp_seg(cur.v, cur.d, di, 1'b1);
      end
      check("digit_en_n", 16'(digit_en_n), 16'(ed));
      check("seg_n", 16'(seg_n), 16'(es));
      check("digit_en_n_lz", 16'(digit_en_n_lz), 16'(ed));
      check("seg_n_lz", 16'(seg_n_lz), 16'(esl));
      rst_prev = rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      sc++;
   endtask

   task automatic go_to(input int n);
      while (sc < n) tick();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input bit expect_apply);
      load  = 1'b1;
      value = v;
      dp    = d;
      if (expect_apply) exp_q.push_back('{v: v, d: d});
      tick();
      load = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      load  = 1'b0;
      value = 16'h0;
      dp    = 4'h0;

      @(posedge clk); #1;
      check("rst_seg_n", 16'(seg_n), 16'h00FF);
      check("rst_digit_en_n", 16'(digit_en_n), 16'h000F);
      check("rst_frame_start", 16'(frame_start), 16'h0);
      check("rst_load_ack", 16'(load_ack), 16'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      sc  = 0;
      #1;
      check("first_frame_start", 16'(frame_start), 16'h1);

      // Basic load, applied at the frame 1 boundary.
      go_to(5);   do_load(16'h1234, 4'b0000, 1'b1);
      go_to(40);  check("ack_frame1", 16'(load_ack), 16'h1);
      go_to(41);  check("queue_drained_f1", 16'(exp_q.size()), 16'h0);
      go_to(42);  check("d0_seg_4", 16'(seg_n), 16'h0099);
                  check("d0_en", 16'(digit_en_n), 16'h000E);
      go_to(52);  check("d1_seg_3", 16'(seg_n), 16'h00B0);
                  check("d1_en", 16'(digit_en_n), 16'h000D);

      // Free run, then two loads mid-frame: last write wins, one ack, no tearing.
      go_to(165); do_load(16'hABCD, 4'b0101, 1'b0);
      go_to(167); do_load(16'h00F0, 4'b1010, 1'b1);
      go_to(190); check("no_early_transfer", 16'(exp_q.size()), 16'h1);
      go_to(195); check("no_tearing_d3", 16'(seg_n), 16'h00F9);
      go_to(200); check("ack_00f0", 16'(load_ack), 16'h1);
      go_to(201); check("queue_drained_00f0", 16'(exp_q.size()), 16'h0);
      go_to(202); check("d0_seg_0", 16'(seg_n), 16'h00C0);
      go_to(212); check("d1_seg_F_dp", 16'(seg_n), 16'h000E);

      // Load coincident with the transfer cycle.
      go_to(215); do_load(16'h5678, 4'b0000, 1'b1);
      go_to(240); check("ack_old_stage", 16'(load_ack), 16'h1);
                  do_load(16'h9ABC, 4'b0001, 1'b1);
      check("new_data_still_pending", 16'(exp_q.size()), 16'h1);
      go_to(242); check("d0_seg_8", 16'(seg_n), 16'h0080);
      go_to(280); check("second_ack", 16'(load_ack), 16'h1);
      go_to(282); check("d0_seg_C_dp", 16'(seg_n), 16'h0046);

      // Leading-zero blanking.
      go_to(290); do_load(16'h0005, 4'b0100, 1'b1);
      go_to(320); check("ack_lz", 16'(load_ack_lz), 16'h1);
      go_to(322); check("lz_d0_seg_5", 16'(seg_n_lz), 16'h0092);
      go_to(332); check("lz_d1_blank", 16'(seg_n_lz), 16'h00FF);
                  check("lz_d1_en", 16'(digit_en_n_lz), 16'h000D);
                  check("nolz_d1_seg_0", 16'(seg_n), 16'h00C0);
      go_to(342); check("lz_d2_dp_only", 16'(seg_n_lz), 16'h007F);
                  check("nolz_d2_seg_0_dp", 16'(seg_n), 16'h0040);
      go_to(352); check("lz_d3_blank", 16'(seg_n_lz), 16'h00FF);

      // Reset mid digit-2 slot with a pending load.
      go_to(365); do_load(16'h4321, 4'b1111, 1'b0);
      go_to(385);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sc  = 0;
      check("mid_rst_seg_blank", 16'(seg_n), 16'h00FF);
      check("mid_rst_en_off", 16'(digit_en_n), 16'h000F);
      #1;
      check("mid_rst_frame_start", 16'(frame_start), 16'h1);
      check("mid_rst_no_ack", 16'(load_ack), 16'h0);
      go_to(42);  check("post_rst_d0_seg_0", 16'(seg_n), 16'h00C0);
                  check("post_rst_d0_en", 16'(digit_en_n), 16'h000E);
                  check("post_rst_lz_d0", 16'(seg_n_lz), 16'h00C0);
      go_to(80);  check("post_rst_frame1", 16'(frame_start), 16'h1);
                  check("post_rst_no_ack", 16'(load_ack), 16'h0);
      go_to(85);  check("final_queue_empty", 16'(exp_q.size()), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
